// File: rtl/if_id_buffer_pkg.sv
// Shared IF/ID definitions: EXTOp encodings for the immediate extender and
// the opcodes that select them.
package if_id_buffer_pkg;

    typedef enum logic [1:0] {
        LogicEXT      = 2'b00,
        ArithmeticEXT = 2'b01,
        LUIEXT        = 2'b10
    } ext_op_e;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

endpackage

// File: rtl/if_id_buffer_ext_op_decode.sv
// Combinational opcode -> EXTOp decoder; shared by the IF/ID pre-decode
// path and the main ID decoder.
module ext_op_decode
    import if_id_buffer_pkg::*;
(
    input  logic [5:0] op,
    output logic [1:0] ext_op
);

    // Logical immediates zero-extend, LUI shifts, everything else sign-extends.
    always_comb begin
        ext_op = ArithmeticEXT;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: ext_op = LogicEXT;
            OP_LUI:                   ext_op = LUIEXT;
            default:                  ext_op = ArithmeticEXT;
        endcase
    end

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID stage: output register plus one skid entry, with EXTOp pre-decoded
// at capture. Optional stall counter enabled by `define IF_ID_STALL_CNT_EN.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               if_valid,
    output logic               if_ready,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [INSTR_W-1:0] if_instr,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [4:0]         id_rs,
    output logic [4:0]         id_rt,
    output logic [15:0]        Imm16,
`ifdef IF_ID_STALL_CNT_EN
    output logic [31:0]        stall_cnt,
`endif
    output logic [1:0]         EXTOp
);

    logic               out_valid_r, out_valid_s;
    logic [PC_W-1:0]    out_pc_r, out_pc_s;
    logic [INSTR_W-1:0] out_instr_r, out_instr_s;
    logic [1:0]         out_ext_r, out_ext_s;
    logic               skid_valid_r, skid_valid_s;
    logic [PC_W-1:0]    skid_pc_r, skid_pc_s;
    logic [INSTR_W-1:0] skid_instr_r, skid_instr_s;
    logic [1:0]         skid_ext_r, skid_ext_s;
    logic               if_ready_r;
    logic [1:0]         in_ext_s;
    logic               accept_s;
    logic               out_free_s;

    ext_op_decode u_ext_op_decode (
        .op     (if_instr[31:26]),
        .ext_op (in_ext_s)
    );

    assign accept_s   = if_valid && if_ready_r;
    assign out_free_s = !out_valid_r || id_ready;

    // Next-state of the OUT/SKID pair; flush wins over any transfer.
    always_comb begin
        out_valid_s  = out_valid_r;
        out_pc_s     = out_pc_r;
        out_instr_s  = out_instr_r;
        out_ext_s    = out_ext_r;
        skid_valid_s = skid_valid_r;
        skid_pc_s    = skid_pc_r;
        skid_instr_s = skid_instr_r;
        skid_ext_s   = skid_ext_r;
        if (flush) begin
            out_valid_s  = 1'b0;
            skid_valid_s = 1'b0;
        end else if (out_free_s && skid_valid_r) begin
            out_valid_s  = 1'b1;
            out_pc_s     = skid_pc_r;
            out_instr_s  = skid_instr_r;
            out_ext_s    = skid_ext_r;
            skid_valid_s = accept_s;
            skid_pc_s    = accept_s ? if_pc    : skid_pc_r;
            skid_instr_s = accept_s ? if_instr : skid_instr_r;
            skid_ext_s   = accept_s ? in_ext_s : skid_ext_r;
        end else if (out_free_s) begin
            out_valid_s  = accept_s;
            out_pc_s     = accept_s ? if_pc    : out_pc_r;
            out_instr_s  = accept_s ? if_instr : out_instr_r;
            out_ext_s    = accept_s ? in_ext_s : out_ext_r;
        end else if (accept_s) begin
            skid_valid_s = 1'b1;
            skid_pc_s    = if_pc;
            skid_instr_s = if_instr;
            skid_ext_s   = in_ext_s;
        end else begin
            skid_valid_s = skid_valid_r;
        end
    end

    // Pipeline state; if_ready is registered from the next skid occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_pc_r     <= {PC_W{1'b0}};
            out_instr_r  <= {INSTR_W{1'b0}};
            out_ext_r    <= LogicEXT;
            skid_valid_r <= 1'b0;
            skid_pc_r    <= {PC_W{1'b0}};
            skid_instr_r <= {INSTR_W{1'b0}};
            skid_ext_r   <= LogicEXT;
            if_ready_r   <= 1'b1;
        end else begin
            out_valid_r  <= out_valid_s;
            out_pc_r     <= out_pc_s;
            out_instr_r  <= out_instr_s;
            out_ext_r    <= out_ext_s;
            skid_valid_r <= skid_valid_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
            skid_ext_r   <= skid_ext_s;
            if_ready_r   <= !skid_valid_s;
        end
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of ID-side stall cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (out_valid_r && !id_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign if_ready = if_ready_r;
    assign id_valid = out_valid_r;
    assign id_pc    = out_pc_r;
    assign id_instr = out_instr_r;
    assign id_rs    = out_instr_r[25:21];
    assign id_rt    = out_instr_r[20:16];
    assign Imm16    = out_instr_r[15:0];
    assign EXTOp    = out_ext_r;

endmodule
